// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM plus MMIO window (console FIFO, status,
// cycle counter, halt) answering the core's level-held data requests.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_mem_data_r_en/_addr   read request (level) and byte address
//   o_mem_data_r_data       registered read data, holds while r_en=0
//   i_mem_data_w_en/_addr   write request (level), byte address
//   i_mem_data_w_data       write data
//   o_con_valid/o_con_data  console FIFO head, popped by i_con_ready
//   o_halt/o_halt_code      sticky halt request and last HALT value
//   o_err                   sticky OR of misaligned/out-of-range/overflow
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_mem_data_r_en,
   input  logic [31:0] i_mem_data_r_addr,
   output logic [31:0] o_mem_data_r_data,
   input  logic        i_mem_data_w_en,
   input  logic [31:0] i_mem_data_w_addr,
   input  logic [31:0] i_mem_data_w_data,
   output logic        o_con_valid,
   output logic [7:0]  o_con_data,
   input  logic        i_con_ready,
   output logic        o_halt,
   output logic [31:0] o_halt_code,
   output logic        o_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam logic [29:0] MMIO_W  = MMIO_BASE[31:2];
   localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
   localparam logic [FW:0] CNT_FULL = (FW+1)'(FIFO_DEPTH);

   logic [31:0]   r_ram [DEPTH_WORDS];
   logic [7:0]    r_fifo [FIFO_DEPTH];

   logic [31:0]   r_rdata;
   logic          r_w_en_q;
   logic [31:0]   r_cycle;
   logic [FW-1:0] r_wptr;
   logic [FW-1:0] r_rptr;
   logic [FW:0]   r_count;
   logic          r_mis;
   logic          r_oor;
   logic          r_ovf;
   logic          r_halt;
   logic [31:0]   r_halt_code;

   // Read-side decode
   logic          w_r_mmio;
   logic [29:0]   w_r_off;
   logic          w_r_oor;
   logic          w_r_mis;
   logic [31:0]   w_rd_val;

   // Write-side decode
   logic          w_w_mmio;
   logic [29:0]   w_w_off;
   logic          w_w_oor;
   logic          w_w_mis;
   logic          w_commit;
   logic          w_ram_we;
   logic          w_push;
   logic          w_halt_we;

   // FIFO control
   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_push_ok;
   logic          w_ovf;
   logic [7:0]    w_cnt8;
   logic [31:0]   w_status;

   assign w_r_mmio = i_mem_data_r_addr >= MMIO_BASE;
   assign w_r_off  = i_mem_data_r_addr[31:2] - MMIO_W;
   assign w_r_oor  = !w_r_mmio &&
                     ({2'b00, i_mem_data_r_addr[31:2]} >= DEPTH_L);
   assign w_r_mis  = |i_mem_data_r_addr[1:0];

   assign w_w_mmio = i_mem_data_w_addr >= MMIO_BASE;
   assign w_w_off  = i_mem_data_w_addr[31:2] - MMIO_W;
   assign w_w_oor  = !w_w_mmio &&
                     ({2'b00, i_mem_data_w_addr[31:2]} >= DEPTH_L);
   assign w_w_mis  = |i_mem_data_w_addr[1:0];

   // Only the first cycle of a held store commits; reset blocks it.
   assign w_commit  = i_mem_data_w_en & ~r_w_en_q & ~i_rst;
   assign w_ram_we  = w_commit & ~w_w_mmio & ~w_w_oor;
   assign w_push    = w_commit & w_w_mmio & (w_w_off == 30'd0);
   assign w_halt_we = w_commit & w_w_mmio & (w_w_off == 30'd3);

   assign w_empty   = r_count == '0;
   assign w_full    = r_count == CNT_FULL;
   assign w_pop     = ~w_empty & i_con_ready;
   // A pop on the same edge frees the slot for a push at full.
   assign w_push_ok = w_push & (~w_full | w_pop);
   assign w_ovf     = w_push & w_full & ~w_pop;

   assign w_cnt8   = 8'(r_count);
   assign w_status = {16'b0, w_cnt8, 4'b0, r_ovf, r_oor, r_mis, w_full};

   always_comb begin
      w_rd_val = '0;
      if (w_r_mmio) begin
         case (w_r_off)
            30'd1:   w_rd_val = w_status;
            30'd2:   w_rd_val = r_cycle;
            default: w_rd_val = '0;
         endcase
      end else if (!w_r_oor) begin
         w_rd_val = r_ram[i_mem_data_r_addr[AW+1:2]];
      end
   end

   // Storage arrays are not reset.
   always_ff @(posedge i_clk) begin
      if (w_ram_we)
         r_ram[i_mem_data_w_addr[AW+1:2]] <= i_mem_data_w_data;
      if (w_push_ok)
         r_fifo[r_wptr] <= i_mem_data_w_data[7:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata     <= '0;
         r_w_en_q    <= 1'b0;
         r_cycle     <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_mis       <= 1'b0;
         r_oor       <= 1'b0;
         r_ovf       <= 1'b0;
         r_halt      <= 1'b0;
         r_halt_code <= '0;
      end else begin
         r_w_en_q <= i_mem_data_w_en;
         r_cycle  <= r_cycle + 32'd1;
         if (i_mem_data_r_en)
            r_rdata <= w_rd_val;
         if ((i_mem_data_r_en & w_r_mis) | (w_commit & w_w_mis))
            r_mis <= 1'b1;
         if ((i_mem_data_r_en & w_r_oor) | (w_commit & w_w_oor))
            r_oor <= 1'b1;
         if (w_ovf)
            r_ovf <= 1'b1;
         if (w_halt_we) begin
            r_halt      <= 1'b1;
            r_halt_code <= i_mem_data_w_data;
         end
         if (w_push_ok)
            r_wptr <= r_wptr + FW'(1);
         if (w_pop)
            r_rptr <= r_rptr + FW'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + (FW+1)'(1);
            2'b01:   r_count <= r_count - (FW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_mem_data_r_data = r_rdata;
   assign o_con_valid       = ~w_empty;
   assign o_con_data        = w_empty ? 8'h00 : r_fifo[r_rptr];
   assign o_halt            = r_halt;
   assign o_halt_code       = r_halt_code;
   assign o_err             = r_mis | r_oor | r_ovf;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for
// data_mem_responder (RAM, console FIFO, status, cycle, halt, reset).
module tb_data_mem_responder;

   localparam logic [31:0] CON  = 32'h8000_0000;
   localparam logic [31:0] STAT = 32'h8000_0004;
   localparam logic [31:0] CYC  = 32'h8000_0008;
   localparam logic [31:0] HLT  = 32'h8000_000C;

   logic        clk;
   logic        rst;
   logic        r_en;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic        w_en;
   logic [31:0] w_addr;
   logic [31:0] w_data;
   logic        con_valid;
   logic [7:0]  con_data;
   logic        con_ready;
   logic        halt;
   logic [31:0] halt_code;
   logic        err;

   int checks;
   int failures;

   data_mem_responder #(
      .DEPTH_WORDS (1024),
      .MMIO_BASE   (32'h8000_0000),
      .FIFO_DEPTH  (8)
   ) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_mem_data_r_en   (r_en),
      .i_mem_data_r_addr (r_addr),
      .o_mem_data_r_data (r_data),
      .i_mem_data_w_en   (w_en),
      .i_mem_data_w_addr (w_addr),
      .i_mem_data_w_data (w_data),
      .o_con_valid       (con_valid),
      .o_con_data        (con_data),
      .i_con_ready       (con_ready),
      .o_halt            (halt),
      .o_halt_code       (halt_code),
      .o_err             (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Core-style store: request held two cycles, then one idle cycle.
   task automatic store(input logic [31:0] a, input logic [31:0] d);
      w_en   = 1'b1;
      w_addr = a;
      w_data = d;
      tick();
      tick();
      w_en = 1'b0;
      tick();
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      r_en   = 1'b1;
      r_addr = a;
      tick();
      r_en = 1'b0;
      d    = r_data;
   endtask

   logic [31:0] v;
   logic [31:0] c1;
   logic [31:0] c2;

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      r_en      = 1'b0;
      r_addr    = '0;
      w_en      = 1'b0;
      w_addr    = '0;
      w_data    = '0;
      con_ready = 1'b0;
      tick();
      tick();
      chk("rst_rdata", r_data, 32'h0);
      chk("rst_valid", {31'b0, con_valid}, 32'h0);
      chk("rst_cdata", {24'b0, con_data}, 32'h0);
      chk("rst_halt", {31'b0, halt}, 32'h0);
      chk("rst_hcode", halt_code, 32'h0);
      chk("rst_err", {31'b0, err}, 32'h0);
      rst = 1'b0;
      tick();

      // RAM store then read
      store(32'h10, 32'hDEAD_BEEF);
      rd(32'h10, v);
      chk("ram_rd", v, 32'hDEAD_BEEF);
      r_addr = 32'h14;
      tick();
      chk("rd_hold", r_data, 32'hDEAD_BEEF);

      // Held second cycle must not write again
      w_en   = 1'b1;
      w_addr = 32'h14;
      w_data = 32'h1111_1111;
      tick();
      w_data = 32'h2222_2222;
      tick();
      w_en = 1'b0;
      tick();
      rd(32'h14, v);
      chk("commit_once", v, 32'h1111_1111);

      // Read-before-write on the same edge
      store(32'h18, 32'h0000_0001);
      r_en   = 1'b1;
      r_addr = 32'h18;
      w_en   = 1'b1;
      w_addr = 32'h18;
      w_data = 32'h0000_0002;
      tick();
      r_en = 1'b0;
      chk("rbw_old", r_data, 32'h0000_0001);
      tick();
      w_en = 1'b0;
      tick();
      rd(32'h18, v);
      chk("rbw_new", v, 32'h0000_0002);

      // Console: three bytes, then drain
      store(CON, 32'h41);
      store(CON, 32'h42);
      store(CON, 32'h43);
      rd(STAT, v);
      chk("stat_cnt3", v, 32'h0000_0300);
      chk("con_head", {24'b0, con_data}, 32'h41);
      con_ready = 1'b1;
      tick();
      chk("con_2nd", {24'b0, con_data}, 32'h42);
      tick();
      chk("con_3rd", {24'b0, con_data}, 32'h43);
      tick();
      chk("con_empty", {31'b0, con_valid}, 32'h0);
      con_ready = 1'b0;

      // Fill to full, push+pop at full, then overflow
      for (int i = 0; i < 8; i++)
         store(CON, 32'h50 + 32'(i));
      rd(STAT, v);
      chk("stat_full", v, 32'h0000_0801);
      w_en      = 1'b1;
      w_addr    = CON;
      w_data    = 32'h58;
      con_ready = 1'b1;
      tick();
      con_ready = 1'b0;
      tick();
      w_en = 1'b0;
      tick();
      rd(STAT, v);
      chk("full_pushpop", v, 32'h0000_0801);
      chk("no_ovf_err", {31'b0, err}, 32'h0);
      store(CON, 32'h59);
      rd(STAT, v);
      chk("stat_ovf", v, 32'h0000_0809);
      chk("ovf_err", {31'b0, err}, 32'h1);
      con_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain", {24'b0, con_data}, 32'h51 + 32'(i));
         tick();
      end
      chk("drain_empty", {31'b0, con_valid}, 32'h0);
      con_ready = 1'b0;

      // Misaligned and out-of-range accesses
      store(32'h0, 32'h0BAD_F00D);
      store(32'h4, 32'hCAFE_F00D);
      rd(32'h6, v);
      chk("mis_rd", v, 32'hCAFE_F00D);
      rd(STAT, v);
      chk("stat_mis", v, 32'h0000_000A);
      rd(32'h1000, v);
      chk("oor_rd", v, 32'h0);
      rd(STAT, v);
      chk("stat_oor", v, 32'h0000_000E);
      store(32'h1000, 32'h1234_5678);
      rd(32'h0, v);
      chk("oor_wr_drop", v, 32'h0BAD_F00D);
      rd(32'h8000_0010, v);
      chk("mmio_other", v, 32'h0);

      // HALT
      w_en   = 1'b1;
      w_addr = HLT;
      w_data = 32'h2A;
      tick();
      chk("halt_rise", {31'b0, halt}, 32'h1);
      tick();
      w_en = 1'b0;
      tick();
      chk("halt_code", halt_code, 32'h2A);
      store(HLT, 32'h55);
      chk("halt_sticky", {31'b0, halt}, 32'h1);
      chk("halt_code2", halt_code, 32'h55);

      // CYCLE difference over 5 edges
      rd(CYC, c1);
      tick();
      tick();
      tick();
      tick();
      rd(CYC, c2);
      chk("cycle_diff", c2 - c1, 32'd5);

      // Reset during a held store
      store(32'h40, 32'hAAAA_0000);
      store(CON, 32'h77);
      rd(32'h40, v);
      w_en   = 1'b1;
      w_addr = 32'h40;
      w_data = 32'hBBBB_0000;
      rst    = 1'b1;
      tick();
      chk("mrst_rdata", r_data, 32'h0);
      chk("mrst_valid", {31'b0, con_valid}, 32'h0);
      chk("mrst_cdata", {24'b0, con_data}, 32'h0);
      chk("mrst_halt", {31'b0, halt}, 32'h0);
      chk("mrst_hcode", halt_code, 32'h0);
      chk("mrst_err", {31'b0, err}, 32'h0);
      w_en = 1'b0;
      rst  = 1'b0;
      tick();
      rd(32'h40, v);
      chk("mrst_nowr", v, 32'hAAAA_0000);

      // w_en held across reset release commits once released
      w_en   = 1'b1;
      w_addr = 32'h40;
      w_data = 32'hCCCC_0000;
      rst    = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      w_en = 1'b0;
      tick();
      rd(32'h40, v);
      chk("rst_rel_wr", v, 32'hCCCC_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
